// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================================
// Module      : pc_gen
// Description : Fetch PC generator for the out-of-order front end. Issues one
//               aligned fetch block per accepted handshake and applies
//               prioritised redirects (trap/mret > branch > jump). A redirect
//               seen while the core is disabled is parked until cpu_en rises.
//               Every redirect that reaches pc bumps the fetch epoch.
//               Optional macro PC_GEN_PERF_EN adds saturating counters for
//               accepted redirects and fetch handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_gen #(
    parameter int                  PC_WIDTH    = 32,
    parameter int                  FETCH_WIDTH = 2,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
    parameter int                  EPOCH_WIDTH = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cpu_en,
    input  logic                   pc_stall,
    input  logic                   trap_happened,
    input  logic [2:0]             rob_commit_ebreak_ecall_mret,
    input  logic [PC_WIDTH-1:0]    ctrl_pc,
    input  logic                   br_taken,
    input  logic [PC_WIDTH-1:0]    br_addr,
    input  logic                   jp_taken,
    input  logic [PC_WIDTH-1:0]    jp_addr,
    input  logic                   fetch_ready,
    output logic                   fetch_valid,
    output logic [PC_WIDTH-1:0]    fetch_pc,
    output logic [FETCH_WIDTH-1:0] fetch_mask,
    output logic [EPOCH_WIDTH-1:0] fetch_epoch,
    output logic                   misaligned_target
`ifdef PC_GEN_PERF_EN
    ,
    output logic [31:0]            perf_redirects,
    output logic [31:0]            perf_blocks
`endif
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_HOLD = 2'd2;

    // Slot-offset field width inside an aligned block (at least 1 bit).
    localparam int c_OFF_W = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
    localparam logic [PC_WIDTH-1:0] c_BLK_BYTES = PC_WIDTH'(FETCH_WIDTH * 4);
    localparam logic [PC_WIDTH-1:0] c_BLK_MASK  = c_BLK_BYTES - PC_WIDTH'(1);
    localparam logic [PC_WIDTH-1:0] c_WORD_MASK = PC_WIDTH'(3);

    logic [1:0]             r_state;
    logic [PC_WIDTH-1:0]    r_pc;
    logic [PC_WIDTH-1:0]    r_pend_pc;
    logic [EPOCH_WIDTH-1:0] r_epoch;
    logic                   r_misaligned;

    logic [1:0]             w_state_nxt;
    logic [PC_WIDTH-1:0]    w_pc_nxt;
    logic [PC_WIDTH-1:0]    w_pend_nxt;
    logic [EPOCH_WIDTH-1:0] w_epoch_nxt;

    logic                   w_redirect;
    logic [PC_WIDTH-1:0]    w_target;
    logic [PC_WIDTH-1:0]    w_target_aln;
    logic [PC_WIDTH-1:0]    w_pc_seq;
    logic                   w_valid;
    logic                   w_fire;
    logic                   w_unused;

    // Only the mret bit of the commit vector steers the PC.
    assign w_unused = &{1'b0, rob_commit_ebreak_ecall_mret[2:1]};

    // Redirect request and its prioritised, word-aligned target.
    assign w_redirect   = trap_happened | rob_commit_ebreak_ecall_mret[0] | br_taken | jp_taken;
    assign w_target     = (trap_happened | rob_commit_ebreak_ecall_mret[0]) ? ctrl_pc :
                          br_taken                                          ? br_addr :
                                                                              jp_addr;
    assign w_target_aln = w_target & ~c_WORD_MASK;

    // Next sequential block: align down to the block, step one block (wraps).
    assign w_pc_seq = (r_pc & ~c_BLK_MASK) + c_BLK_BYTES;

    assign w_valid = (r_state == c_ST_RUN) & cpu_en & ~pc_stall & ~w_redirect;
    assign w_fire  = w_valid & fetch_ready;

    // Next-state, next-pc and epoch decisions.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_pend_nxt  = r_pend_pc;
        w_epoch_nxt = r_epoch;
        case (r_state)
            c_ST_IDLE: begin
                if (w_redirect) begin
                    w_state_nxt = c_ST_HOLD;
                    w_pend_nxt  = w_target_aln;
                end else if (cpu_en) begin
                    w_state_nxt = c_ST_RUN;
                end
            end
            c_ST_RUN: begin
                if (w_redirect) begin
                    if (cpu_en) begin
                        w_pc_nxt    = w_target_aln;
                        w_epoch_nxt = r_epoch + 1'b1;
                    end else begin
                        w_state_nxt = c_ST_HOLD;
                        w_pend_nxt  = w_target_aln;
                    end
                end else if (!cpu_en) begin
                    w_state_nxt = c_ST_IDLE;
                end else if (w_fire) begin
                    w_pc_nxt = w_pc_seq;
                end
            end
            c_ST_HOLD: begin
                if (cpu_en) begin
                    // A redirect arriving on the release cycle replaces the parked one.
                    w_state_nxt = c_ST_RUN;
                    w_pc_nxt    = w_redirect ? w_target_aln : r_pend_pc;
                    w_epoch_nxt = r_epoch + 1'b1;
                end else if (w_redirect) begin
                    w_pend_nxt = w_target_aln;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // State, pc, epoch, parked target and misalignment pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_pc         <= RESET_PC;
            r_pend_pc    <= '0;
            r_epoch      <= '0;
            r_misaligned <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_pend_pc    <= w_pend_nxt;
            r_epoch      <= w_epoch_nxt;
            r_misaligned <= w_redirect & (|w_target[1:0]);
        end
    end

    assign fetch_valid       = w_valid;
    assign fetch_pc          = r_pc;
    assign fetch_epoch       = r_epoch;
    assign misaligned_target = r_misaligned;

    generate
        if (FETCH_WIDTH == 1) begin : g_mask_single
            assign fetch_mask = 1'b1;
        end else begin : g_mask_multi
            logic [c_OFF_W-1:0] w_off;
            assign w_off = r_pc[c_OFF_W+1:2];
            for (genvar i = 0; i < FETCH_WIDTH; i++) begin : g_slot
                assign fetch_mask[i] = (w_off <= c_OFF_W'(i));
            end
        end
    endgenerate

`ifdef PC_GEN_PERF_EN
    logic [31:0] r_perf_redirects;
    logic [31:0] r_perf_blocks;

    // Saturating counters of accepted redirects and fetch handshakes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_redirects <= '0;
            r_perf_blocks    <= '0;
        end else begin
            if (w_redirect && (r_perf_redirects != '1)) begin
                r_perf_redirects <= r_perf_redirects + 32'd1;
            end
            if (w_fire && (r_perf_blocks != '1)) begin
                r_perf_blocks <= r_perf_blocks + 32'd1;
            end
        end
    end

    assign perf_redirects = r_perf_redirects;
    assign perf_blocks    = r_perf_blocks;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pc_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_gen
// Description : Self-checking bench for pc_gen. A behavioural model tracks the
//               expected pc/epoch/mode and is compared on every falling edge;
//               directed steps pin literal values, then random traffic runs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_gen;

    localparam int          c_FW       = 2;
    localparam logic [31:0] c_RESET_PC = 32'h80;

    logic        clk;
    logic        rst;
    logic        cpu_en;
    logic        pc_stall;
    logic        trap_happened;
    logic [2:0]  rob_commit_ebreak_ecall_mret;
    logic [31:0] ctrl_pc;
    logic        br_taken;
    logic [31:0] br_addr;
    logic        jp_taken;
    logic [31:0] jp_addr;
    logic        fetch_ready;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic [1:0]  fetch_mask;
    logic [2:0]  fetch_epoch;
    logic        misaligned_target;
`ifdef PC_GEN_PERF_EN
    logic [31:0] perf_redirects;
    logic [31:0] perf_blocks;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    pc_gen #(
        .PC_WIDTH    (32),
        .FETCH_WIDTH (c_FW),
        .RESET_PC    (c_RESET_PC),
        .EPOCH_WIDTH (3)
    ) u_dut (
        .clk                          (clk),
        .rst                          (rst),
        .cpu_en                       (cpu_en),
        .pc_stall                     (pc_stall),
        .trap_happened                (trap_happened),
        .rob_commit_ebreak_ecall_mret (rob_commit_ebreak_ecall_mret),
        .ctrl_pc                      (ctrl_pc),
        .br_taken                     (br_taken),
        .br_addr                      (br_addr),
        .jp_taken                     (jp_taken),
        .jp_addr                      (jp_addr),
        .fetch_ready                  (fetch_ready),
        .fetch_valid                  (fetch_valid),
        .fetch_pc                     (fetch_pc),
        .fetch_mask                   (fetch_mask),
        .fetch_epoch                  (fetch_epoch),
        .misaligned_target            (misaligned_target)
`ifdef PC_GEN_PERF_EN
        ,
        .perf_redirects               (perf_redirects),
        .perf_blocks                  (perf_blocks)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural model: what the front end should look like after each edge.
    logic [31:0] m_pc;
    logic [31:0] m_pend;
    logic [2:0]  m_epoch;
    logic        m_running;
    logic        m_parked;
    logic        m_mis;
    logic        m_known = 1'b0;

    always @(negedge clk) begin : model
        logic        redir;
        logic [31:0] tgt;
        logic [31:0] atgt;
        logic        exp_valid;
        logic [1:0]  exp_mask;
        int          off;

        redir = trap_happened | rob_commit_ebreak_ecall_mret[0] | br_taken | jp_taken;
        if (trap_happened || rob_commit_ebreak_ecall_mret[0]) tgt = ctrl_pc;
        else if (br_taken)                                    tgt = br_addr;
        else                                                  tgt = jp_addr;
        atgt = (tgt / 4) * 4;

        if (m_known) begin
            exp_valid = m_running & cpu_en & ~pc_stall & ~redir;
            off = int'((m_pc / 4) % c_FW);
            for (int i = 0; i < c_FW; i++) exp_mask[i] = (i >= off);
            chk("model_pc",    fetch_pc,           m_pc);
            chk("model_epoch", 32'(fetch_epoch),   32'(m_epoch));
            chk("model_valid", 32'(fetch_valid),   32'(exp_valid));
            chk("model_mask",  32'(fetch_mask),    32'(exp_mask));
            chk("model_mis",   32'(misaligned_target), 32'(m_mis));
        end

        if (rst) begin
            m_known   = 1'b1;
            m_pc      = c_RESET_PC;
            m_pend    = 32'h0;
            m_epoch   = 3'd0;
            m_running = 1'b0;
            m_parked  = 1'b0;
            m_mis     = 1'b0;
        end else if (m_known) begin
            m_mis = redir && (tgt % 4 != 0);
            if (m_running) begin
                if (redir && cpu_en) begin
                    m_pc    = atgt;
                    m_epoch = m_epoch + 3'd1;
                end else if (redir) begin
                    m_running = 1'b0;
                    m_parked  = 1'b1;
                    m_pend    = atgt;
                end else if (!cpu_en) begin
                    m_running = 1'b0;
                end else if (!pc_stall && fetch_ready) begin
                    m_pc = ((m_pc / (c_FW * 4)) + 1) * (c_FW * 4);
                end
            end else if (m_parked) begin
                if (redir) m_pend = atgt;
                if (cpu_en) begin
                    m_pc      = m_pend;
                    m_epoch   = m_epoch + 3'd1;
                    m_parked  = 1'b0;
                    m_running = 1'b1;
                end
            end else begin
                if (redir) begin
                    m_parked = 1'b1;
                    m_pend   = atgt;
                end else if (cpu_en) begin
                    m_running = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; cpu_en = 1'b0; pc_stall = 1'b0; fetch_ready = 1'b0;
        trap_happened = 1'b0; rob_commit_ebreak_ecall_mret = 3'b000; ctrl_pc = 32'h0;
        br_taken = 1'b0; br_addr = 32'h0; jp_taken = 1'b0; jp_addr = 32'h0;

        // Reset
        tick(); tick(); settle();
        chk("rst_pc", fetch_pc, 32'h80);
        chk("rst_valid", 32'(fetch_valid), 32'd0);
        chk("rst_epoch", 32'(fetch_epoch), 32'd0);
        chk("rst_mis", 32'(misaligned_target), 32'd0);
        tick(); rst = 1'b0; cpu_en = 1'b1; fetch_ready = 1'b1; settle();
        chk("idle_valid", 32'(fetch_valid), 32'd0);
        tick(); settle();
        chk("run_valid", 32'(fetch_valid), 32'd1);
        chk("run_mask", 32'(fetch_mask), 32'h3);
        tick(); settle();
        chk("seq_pc1", fetch_pc, 32'h88);
        // Priority: trap beats branch and jump, no handshake that cycle
        tick();
        trap_happened = 1'b1; ctrl_pc = 32'h100;
        br_taken = 1'b1; br_addr = 32'h200; jp_taken = 1'b1; jp_addr = 32'h300;
        settle();
        chk("seq_pc2", fetch_pc, 32'h90);
        chk("prio_valid", 32'(fetch_valid), 32'd0);
        tick(); trap_happened = 1'b0; br_taken = 1'b0; jp_taken = 1'b0; settle();
        chk("prio_pc", fetch_pc, 32'h100);
        chk("prio_epoch", 32'(fetch_epoch), 32'd1);
        // Unaligned block and backpressure
        tick(); br_taken = 1'b1; br_addr = 32'h204; settle();
        tick(); br_taken = 1'b0; fetch_ready = 1'b0; settle();
        chk("unal_pc", fetch_pc, 32'h204);
        chk("unal_mask", 32'(fetch_mask), 32'h2);
        chk("unal_epoch", 32'(fetch_epoch), 32'd2);
        repeat (3) tick();
        settle();
        chk("bp_pc", fetch_pc, 32'h204);
        tick(); fetch_ready = 1'b1; settle();
        tick(); settle();
        chk("bp_adv_pc", fetch_pc, 32'h208);
        chk("bp_adv_mask", 32'(fetch_mask), 32'h3);
        // Hold: redirects while disabled are parked, newest wins
        tick(); cpu_en = 1'b0; jp_taken = 1'b1; jp_addr = 32'h300; settle();
        chk("hold_valid0", 32'(fetch_valid), 32'd0);
        tick(); jp_taken = 1'b0; br_taken = 1'b1; br_addr = 32'h400; settle();
        tick(); br_taken = 1'b0; settle();
        chk("hold_pc", fetch_pc, 32'h210);
        chk("hold_epoch", 32'(fetch_epoch), 32'd2);
        tick(); cpu_en = 1'b1; settle();
        tick(); settle();
        chk("release_pc", fetch_pc, 32'h400);
        chk("release_epoch", 32'(fetch_epoch), 32'd3);
        // Misaligned target
        tick(); jp_taken = 1'b1; jp_addr = 32'h302; settle();
        tick(); jp_taken = 1'b0; settle();
        chk("mis_pc", fetch_pc, 32'h300);
        chk("mis_pulse", 32'(misaligned_target), 32'd1);
        tick(); settle();
        chk("mis_clear", 32'(misaligned_target), 32'd0);
        // PC wrap at the top block
        tick(); jp_taken = 1'b1; jp_addr = 32'hFFFF_FFF8; settle();
        tick(); jp_taken = 1'b0; settle();
        chk("top_pc", fetch_pc, 32'hFFFF_FFF8);
        tick(); settle();
        chk("wrap_pc", fetch_pc, 32'h0);
        // Eight back-to-back redirects bring the epoch round to where it was
        tick(); br_taken = 1'b1; br_addr = 32'h500;
        repeat (8) tick();
        br_taken = 1'b0; settle();
        chk("ep_wrap_pc", fetch_pc, 32'h500);
        chk("ep_wrap_epoch", 32'(fetch_epoch), 32'd5);
        // Stall blocks advance but not redirects
        tick(); pc_stall = 1'b1; br_taken = 1'b1; br_addr = 32'h600; settle();
        tick(); br_taken = 1'b0; settle();
        chk("stall_redir_pc", fetch_pc, 32'h600);
        chk("stall_valid", 32'(fetch_valid), 32'd0);
        repeat (2) tick();
        settle();
        chk("stall_hold_pc", fetch_pc, 32'h600);
        tick(); pc_stall = 1'b0;

        // Random traffic checked by the model
        for (int c = 0; c < 3000; c++) begin
            tick();
            rst           = ($urandom_range(0, 99) == 0);
            cpu_en        = ($urandom_range(0, 9) != 0);
            pc_stall      = ($urandom_range(0, 4) == 0);
            fetch_ready   = ($urandom_range(0, 3) != 0);
            trap_happened = ($urandom_range(0, 29) == 0);
            rob_commit_ebreak_ecall_mret = {2'($urandom), ($urandom_range(0, 29) == 0)};
            br_taken      = ($urandom_range(0, 14) == 0);
            jp_taken      = ($urandom_range(0, 14) == 0);
            ctrl_pc       = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            br_addr       = $urandom;
            jp_addr       = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
        end
        tick();
        settle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
